l2cache_2way: RTL and testbench
===============================

Name: l2cache_2way

Overview:
- Parametrised two-way set-associative, write-through, write-allocate cache between the CPU memory bus and the SDRAM controller.
- Replaces the direct-mapped L2 with:
  - configurable address, data and index widths;
  - per-set LRU replacement;
  - a configurable cacheable address limit;
  - a sequenced full-cache invalidate (flush) with a busy indication.
- Addresses at or above the cacheable limit bypass the cache combinationally to the SDRAM bus (I/O and ROM space).

Parameters:
- ADDR_W, 24, CPU/SDRAM word-address width.
- DATA_W, 32, data word width.
- INDEX_W, 9, set-index bits; 2^INDEX_W sets, two ways each.
- CACHE_LIMIT, 24'h800000, first non-cacheable address; addr < CACHE_LIMIT is cached.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- cpu_addr  in  ADDR_W  word address
- cpu_data  in  DATA_W  write data
- cpu_we  in  1  write enable
- cpu_start  in  1  request level; a rising edge starts a transaction
- cpu_q  out  DATA_W  read data
- cpu_done  out  1  one-cycle completion pulse
- flush_req  in  1  one-cycle pulse requesting invalidate-all
- busy  out  1  high while a transaction or flush is in progress
- sdc_addr  out  ADDR_W  SDRAM address
- sdc_data  out  DATA_W  SDRAM write data
- sdc_we  out  1  SDRAM write enable
- sdc_start  out  1  SDRAM request level
- sdc_q  in  DATA_W  SDRAM read data
- sdc_done  in  1  SDRAM completion pulse

Behaviour:
- Reset:
  - state FLUSH with the set counter at 0;
  - all valid and LRU bits clear;
  - registered cpu_q, cpu_done, sdc_addr, sdc_data, sdc_we and sdc_start are 0;
  - busy is 1 until the flush completes.
- Storage:
  - per way: a tag array of width ADDR_W-INDEX_W and a data array of width DATA_W, both inferable synchronous-read RAMs with 1-cycle latency;
  - valid[way][set] and lru[set] are register arrays; lru=1 means way 1 is least recently used.
- Transaction capture:
  - a rising edge of cpu_start (start_prev register) in IDLE latches cpu_addr, cpu_data and cpu_we;
  - all later decisions use the latched copies;
  - edges seen outside IDLE are ignored.
- States:
  - IDLE. On an edge with addr < CACHE_LIMIT: present the index to the tag/data RAMs and go to LOOKUP. Otherwise stay in IDLE (bypass).
  - LOOKUP: RAM read cycle; go to COMPARE.
  - COMPARE: hit_w = valid[w] && tag[w] == latched tag.
    - Read hit: cpu_q <= data[hit way]; cpu_done pulses the next cycle; set lru to the other way; go to IDLE.
    - Read miss: sdc_start=1, sdc_we=0, sdc_addr=latched addr; go to MISS.
    - Write (hit or miss): victim = hit way, else the invalid way (way 0 preferred), else the LRU way. Write the tag and data into the victim, set valid, set lru to the other way. Issue the SDRAM write (sdc_we=1, sdc_start=1); go to WWAIT.
  - MISS: on sdc_done:
    - drop sdc_start;
    - fill the victim (chosen by the same rule) with sdc_q;
    - set valid and lru;
    - cpu_q <= sdc_q and pulse cpu_done;
    - go to IDLE.
  - WWAIT: on sdc_done, drop sdc_start/sdc_we, pulse cpu_done, go to IDLE.
  - FLUSH: each cycle clear valid[*][cnt] and lru[cnt]; cnt wraps from 2^INDEX_W-1 to 0 and the state goes to IDLE.
- Latency:
  - read hit: cpu_done high exactly 3 cycles after the cycle in which the edge was sampled;
  - miss/write: 1 cycle after sdc_done.
- Flush:
  - flush_req is held pending if it arrives outside IDLE and is taken on the next IDLE cycle;
  - if it coincides with a start edge in IDLE, the flush wins and the edge is dropped (the CPU re-requests after busy falls).
- Bypass: while cpu_addr >= CACHE_LIMIT, the sdc_* outputs mirror cpu_* and cpu_q/cpu_done mirror sdc_q/sdc_done combinationally; otherwise they are driven from the registered values.
- busy = (state != IDLE) || flush_pending.
- Reset mid-transaction aborts: sdc_start drops the same cycle and the cache flushes. The SDRAM controller must tolerate the abort.

Optional Feature:
- Macro: L2CACHE_PERF_COUNTERS_EN.
- When defined:
  - adds outputs perf_hits[31:0], perf_misses[31:0] and input perf_clear;
  - counts read hits and read misses in COMPARE, saturating at all-ones;
  - counters are cleared by reset or perf_clear, and clear takes priority over increment.
- When undefined: the ports and logic are absent.

Decomposition:
- Shared package l2cache_pkg: state encoding constants (IDLE, LOOKUP, COMPARE, MISS, WWAIT, FLUSH), the tag-width function ADDR_W-INDEX_W, and a victim-select function.
- One sub-module, l2cache_way_ram: a single-port synchronous tag+data RAM with 1-cycle read. It is instantiated twice.

Test Plan:
- Read 0x000123 after reset: SDRAM returns 0xDEADBEEF -> cpu_done pulse and cpu_q=0xDEADBEEF. A repeat read gives a hit with cpu_done 3 cycles after the edge and no sdc_start.
- Three reads mapping to set 5 (A, B, then C): C evicts A. Reading B hits; reading A misses.
- Write 0x000010=0x11 then read it: one SDRAM write, then a read hit returning 0x11.
- Access 0x800004 with sdc_q=0x55: sdc_start follows cpu_start combinationally, cpu_q=0x55, and the cache state is unchanged.
- flush_req during MISS: the miss completes, then busy stays high for 2^INDEX_W cycles. A subsequent read of a previously cached address misses.
- Reset asserted while in WWAIT: sdc_start=0 the next cycle and busy=1 during the flush. With perf counters enabled, perf_hits and perf_misses read 0.

Source files
------------

// File: rtl/l2cache_pkg.sv
// Shared types and helpers for the two-way L2 cache: FSM states, tag width
// and the replacement-way choice.
package l2cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    COMPARE,
    MISS,
    WWAIT,
    FLUSH
  } state_t;

  function automatic int unsigned tag_width(input int unsigned addr_w, input int unsigned index_w);
    return addr_w - index_w;
  endfunction

  // Way to overwrite: the hit way, else an invalid way (way 0 first), else the LRU way.
  function automatic logic victim_sel(input logic hit0, input logic hit1,
                                      input logic valid0, input logic valid1, input logic lru);
    if (hit0)    return 1'b0;
    if (hit1)    return 1'b1;
    if (!valid0) return 1'b0;
    if (!valid1) return 1'b1;
    return lru;
  endfunction

endpackage

// File: rtl/l2cache_2way_if.sv
// CPU-side and SDRAM-side bus of the L2 cache; the cache uses the slave view,
// the CPU/SDRAM environment the master view.
interface l2cache_2way_if #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_data;
  logic              cpu_we;
  logic              cpu_start;
  logic [DATA_W-1:0] cpu_q;
  logic              cpu_done;
  logic              flush_req;
  logic              busy;
  logic [ADDR_W-1:0] sdc_addr;
  logic [DATA_W-1:0] sdc_data;
  logic              sdc_we;
  logic              sdc_start;
  logic [DATA_W-1:0] sdc_q;
  logic              sdc_done;

  modport slave (
    input  cpu_addr, cpu_data, cpu_we, cpu_start, flush_req, sdc_q, sdc_done,
    output cpu_q, cpu_done, busy, sdc_addr, sdc_data, sdc_we, sdc_start
  );

  modport master (
    output cpu_addr, cpu_data, cpu_we, cpu_start, flush_req, sdc_q, sdc_done,
    input  cpu_q, cpu_done, busy, sdc_addr, sdc_data, sdc_we, sdc_start
  );
endinterface

// File: rtl/l2cache_way_ram.sv
// One cache way: single-port tag+data RAM with synchronous 1-cycle read.
module l2cache_way_ram #(
  parameter int unsigned INDEX_W = 9,
  parameter int unsigned TAG_W   = 15,
  parameter int unsigned DATA_W  = 32
) (
  input  logic               clk,
  input  logic               we,
  input  logic [INDEX_W-1:0] addr,
  input  logic [TAG_W-1:0]   wtag,
  input  logic [DATA_W-1:0]  wdata,
  output logic [TAG_W-1:0]   rtag,
  output logic [DATA_W-1:0]  rdata
);
  localparam int unsigned DEPTH = 1 << INDEX_W;

  logic [TAG_W-1:0]  tag_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[addr]  <= wtag;
      data_mem[addr] <= wdata;
    end
    rtag  <= tag_mem[addr];
    rdata <= data_mem[addr];
  end
endmodule

// File: rtl/l2cache_2way.sv
// Two-way set-associative write-through/write-allocate L2 cache with LRU,
// uncached bypass above CACHE_LIMIT and sequenced flush.
// Optional hit/miss counters: define L2CACHE_PERF_COUNTERS_EN.
module l2cache_2way
  import l2cache_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 24,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       INDEX_W     = 9,
  parameter logic [ADDR_W-1:0] CACHE_LIMIT = 24'h800000
) (
  input logic clk,
  input logic reset,
  l2cache_2way_if.slave bus
`ifdef L2CACHE_PERF_COUNTERS_EN
  ,
  input  logic        perf_clear,
  output logic [31:0] perf_hits,
  output logic [31:0] perf_misses
`endif
);
  localparam int unsigned TAG_W = tag_width(ADDR_W, INDEX_W);
  localparam int unsigned SETS  = 1 << INDEX_W;

  state_t state, state_next;

  logic              start_prev, edge_seen, bypass, flush_take, flush_pending;
  logic [ADDR_W-1:0] addr_l;
  logic [DATA_W-1:0] data_l;
  logic              we_l;
  logic [INDEX_W-1:0] cnt, idx_l, ram_addr;
  logic [TAG_W-1:0]  tag_l, rtag0, rtag1;
  logic [DATA_W-1:0] rdata0, rdata1, ram_wdata;
  logic [1:0]        ram_we;
  logic [SETS-1:0]   valid0, valid1, lru;
  logic              hit0, hit1, victim;

  logic [DATA_W-1:0] cpu_q_r, sdc_data_r;
  logic [ADDR_W-1:0] sdc_addr_r;
  logic              cpu_done_r, sdc_we_r, sdc_start_r;

  assign edge_seen  = bus.cpu_start & ~start_prev;
  assign bypass     = bus.cpu_addr >= CACHE_LIMIT;
  assign flush_take = (state == IDLE) && (bus.flush_req || flush_pending);
  assign idx_l      = addr_l[INDEX_W-1:0];
  assign tag_l      = addr_l[ADDR_W-1:INDEX_W];
  assign hit0       = valid0[idx_l] && (rtag0 == tag_l);
  assign hit1       = valid1[idx_l] && (rtag1 == tag_l);
  assign victim     = victim_sel(hit0, hit1, valid0[idx_l], valid1[idx_l], lru[idx_l]);

  l2cache_way_ram #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_way0 (
    .clk(clk), .we(ram_we[0]), .addr(ram_addr), .wtag(tag_l), .wdata(ram_wdata),
    .rtag(rtag0), .rdata(rdata0)
  );

  l2cache_way_ram #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_way1 (
    .clk(clk), .we(ram_we[1]), .addr(ram_addr), .wtag(tag_l), .wdata(ram_wdata),
    .rtag(rtag1), .rdata(rdata1)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= FLUSH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    ram_we     = '0;
    ram_wdata  = data_l;
    // In IDLE the RAMs look up the live CPU index so the tags are ready one cycle earlier.
    ram_addr   = (state == IDLE) ? bus.cpu_addr[INDEX_W-1:0] : idx_l;
    case (state)
      IDLE: begin
        if (flush_take)                  state_next = FLUSH;
        else if (edge_seen && !bypass)   state_next = LOOKUP;
      end
      LOOKUP: state_next = COMPARE;
      COMPARE: begin
        if (we_l) begin
          ram_we[victim] = 1'b1;
          state_next     = WWAIT;
        end else if (hit0 || hit1) begin
          state_next = IDLE;
        end else begin
          state_next = MISS;
        end
      end
      MISS: begin
        if (bus.sdc_done) begin
          ram_wdata      = bus.sdc_q;
          ram_we[victim] = 1'b1;
          state_next     = IDLE;
        end
      end
      WWAIT: if (bus.sdc_done) state_next = IDLE;
      FLUSH: if (cnt == '1) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    start_prev <= bus.cpu_start;
    if (reset) begin
      cnt           <= '0;
      valid0        <= '0;
      valid1        <= '0;
      lru           <= '0;
      flush_pending <= 1'b0;
      cpu_q_r       <= '0;
      cpu_done_r    <= 1'b0;
      sdc_addr_r    <= '0;
      sdc_data_r    <= '0;
      sdc_we_r      <= 1'b0;
      sdc_start_r   <= 1'b0;
    end else begin
      cpu_done_r <= 1'b0;
      if (flush_take)         flush_pending <= 1'b0;
      else if (bus.flush_req) flush_pending <= 1'b1;
      case (state)
        IDLE: begin
          if (flush_take) begin
            cnt <= '0;
          end else if (edge_seen && !bypass) begin
            addr_l <= bus.cpu_addr;
            data_l <= bus.cpu_data;
            we_l   <= bus.cpu_we;
          end
        end
        COMPARE: begin
          if (we_l) begin
            if (victim) valid1[idx_l] <= 1'b1;
            else        valid0[idx_l] <= 1'b1;
            lru[idx_l]  <= ~victim;
            sdc_addr_r  <= addr_l;
            sdc_data_r  <= data_l;
            sdc_we_r    <= 1'b1;
            sdc_start_r <= 1'b1;
          end else if (hit0 || hit1) begin
            cpu_q_r    <= hit1 ? rdata1 : rdata0;
            cpu_done_r <= 1'b1;
            lru[idx_l] <= hit0;
          end else begin
            sdc_addr_r  <= addr_l;
            sdc_we_r    <= 1'b0;
            sdc_start_r <= 1'b1;
          end
        end
        MISS: begin
          if (bus.sdc_done) begin
            sdc_start_r <= 1'b0;
            if (victim) valid1[idx_l] <= 1'b1;
            else        valid0[idx_l] <= 1'b1;
            lru[idx_l] <= ~victim;
            cpu_q_r    <= bus.sdc_q;
            cpu_done_r <= 1'b1;
          end
        end
        WWAIT: begin
          if (bus.sdc_done) begin
            sdc_start_r <= 1'b0;
            sdc_we_r    <= 1'b0;
            cpu_done_r  <= 1'b1;
          end
        end
        FLUSH: begin
          valid0[cnt] <= 1'b0;
          valid1[cnt] <= 1'b0;
          lru[cnt]    <= 1'b0;
          cnt         <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Reset gates sdc_start combinationally so an aborted request drops immediately.
  assign bus.sdc_addr  = bypass ? bus.cpu_addr  : sdc_addr_r;
  assign bus.sdc_data  = bypass ? bus.cpu_data  : sdc_data_r;
  assign bus.sdc_we    = bypass ? bus.cpu_we    : sdc_we_r;
  assign bus.sdc_start = bypass ? bus.cpu_start : (sdc_start_r & ~reset);
  assign bus.cpu_q     = bypass ? bus.sdc_q     : cpu_q_r;
  assign bus.cpu_done  = bypass ? bus.sdc_done  : cpu_done_r;
  assign bus.busy      = (state != IDLE) || flush_pending;

`ifdef L2CACHE_PERF_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (reset || perf_clear) begin
      perf_hits   <= '0;
      perf_misses <= '0;
    end else if (state == COMPARE && !we_l) begin
      if (hit0 || hit1) begin
        if (perf_hits != '1) perf_hits <= perf_hits + 1'b1;
      end else begin
        if (perf_misses != '1) perf_misses <= perf_misses + 1'b1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_l2cache_2way.sv
// Randomized bench for l2cache_2way against a recency-list cache model and an
// SDRAM memory model with random response latency.
module tb_l2cache_2way;
  localparam logic [23:0] LIMIT = 24'h800000;
  localparam int unsigned SETS  = 512;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  l2cache_2way_if #(.ADDR_W(24), .DATA_W(32)) bus ();

`ifdef L2CACHE_PERF_COUNTERS_EN
  logic        perf_clear;
  logic [31:0] perf_hits, perf_misses;
`endif

  l2cache_2way #(.ADDR_W(24), .DATA_W(32), .INDEX_W(9), .CACHE_LIMIT(24'h800000)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef L2CACHE_PERF_COUNTERS_EN
    ,
    .perf_clear(perf_clear),
    .perf_hits(perf_hits),
    .perf_misses(perf_misses)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int sdc_reads = 0, sdc_writes = 0;
  int cyc = 0, resp_done_cyc = 0, done_at = 0;
  int exp_hits = 0, exp_misses = 0;

  logic [31:0] mem [logic [23:0]];
  typedef logic [23:0] addr_q_t[$];
  addr_q_t sets [SETS];   // per set, most recently used first

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [23:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  function automatic bit model_access(input logic [23:0] a);
    int unsigned s = 32'(a[8:0]);
    int pos = -1;
    for (int i = 0; i < sets[s].size(); i++) if (sets[s][i] == a) pos = i;
    if (pos >= 0) sets[s].delete(pos);
    sets[s].push_front(a);
    if (sets[s].size() > 2) void'(sets[s].pop_back());
    return pos >= 0;
  endfunction

  function automatic void model_flush();
    for (int i = 0; i < SETS; i++) sets[i].delete();
  endfunction

  // SDRAM controller model
  initial begin
    int wait_cnt;
    wait_cnt = -1;
    bus.sdc_done = 1'b0;
    bus.sdc_q    = '0;
    forever begin
      @(negedge clk);
      bus.sdc_done = 1'b0;
      if (!bus.sdc_start) wait_cnt = -1;
      else if (wait_cnt == -1) wait_cnt = int'($urandom_range(0, 3));
      else if (wait_cnt == 0) begin
        if (bus.sdc_we) begin
          mem[bus.sdc_addr] = bus.sdc_data;
          sdc_writes++;
        end else begin
          bus.sdc_q = mem_rd(bus.sdc_addr);
          sdc_reads++;
        end
        bus.sdc_done  = 1'b1;
        resp_done_cyc = cyc;
        wait_cnt      = -2;
      end else if (wait_cnt > 0) wait_cnt--;
    end
  end

  task automatic start_req(input logic [23:0] a, input logic w, input logic [31:0] d);
    int guard = 0;
    @(negedge clk);
    @(negedge clk);
    while (bus.busy && guard < 2000) begin @(negedge clk); guard++; end
    if (bus.busy) check("busy_timeout", 64'(bus.busy), 64'd0);
    bus.cpu_addr  = a;
    bus.cpu_data  = d;
    bus.cpu_we    = w;
    bus.cpu_start = 1'b1;
  endtask

  task automatic wait_done(output logic [31:0] q, output int lat);
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!bus.cpu_done && lat < 1000);
    if (!bus.cpu_done) check("done_timeout", 64'(bus.cpu_done), 64'd1);
    q       = bus.cpu_q;
    done_at = cyc;
    bus.cpu_start = 1'b0;
  endtask

  task automatic do_access(input logic [23:0] a, input logic w, input logic [31:0] d, input string name);
    logic [31:0] q;
    int lat, r0, w0;
    bit cacheable, exp_hit;
    cacheable = a < LIMIT;
    exp_hit   = cacheable ? model_access(a) : 1'b0;
    r0 = sdc_reads;
    w0 = sdc_writes;
    start_req(a, w, d);
    wait_done(q, lat);
    if (w) begin
      check({name, "_sdc_writes"}, 64'(sdc_writes - w0), 64'd1);
      check({name, "_mem"}, 64'(mem[a]), 64'(d));
    end else begin
      check({name, "_q"}, 64'(q), 64'(mem[a]));
      check({name, "_sdc_reads"}, 64'(sdc_reads - r0), exp_hit ? 64'd0 : 64'd1);
      if (cacheable && exp_hit) check({name, "_hit_lat"}, 64'(lat), 64'd3);
      if (cacheable) begin
        if (exp_hit) exp_hits++;
        else         exp_misses++;
      end
    end
    if (cacheable && (w || !exp_hit))
      check({name, "_done_after_sdc"}, 64'(done_at - resp_done_cyc), 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] q;
    int lat, n, g;
    reset = 1'b1;
    bus.cpu_addr = '0; bus.cpu_data = '0; bus.cpu_we = 1'b0; bus.cpu_start = 1'b0;
    bus.flush_req = 1'b0;
`ifdef L2CACHE_PERF_COUNTERS_EN
    perf_clear = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_q", 64'(bus.cpu_q), 64'd0);
    check("rst_cpu_done", 64'(bus.cpu_done), 64'd0);
    check("rst_sdc_start", 64'(bus.sdc_start), 64'd0);
    check("rst_sdc_we", 64'(bus.sdc_we), 64'd0);
    check("rst_sdc_addr", 64'(bus.sdc_addr), 64'd0);
    check("rst_sdc_data", 64'(bus.sdc_data), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (bus.busy && n < 2000) begin @(posedge clk); #1; n++; end
    check("rst_flush_len", 64'(n), 64'd512);

    mem[24'h000123] = 32'hDEADBEEF;
    do_access(24'h000123, 1'b0, '0, "rd123_first");
    do_access(24'h000123, 1'b0, '0, "rd123_again");

    do_access(24'h000005, 1'b0, '0, "set5_a");
    do_access(24'h000205, 1'b0, '0, "set5_b");
    do_access(24'h000405, 1'b0, '0, "set5_c");
    do_access(24'h000205, 1'b0, '0, "set5_b2");
    do_access(24'h000005, 1'b0, '0, "set5_a2");

    do_access(24'h000010, 1'b1, 32'h11, "wr10");
    do_access(24'h000010, 1'b0, '0, "rd10");

    mem[24'h800004] = 32'h55;
    start_req(24'h800004, 1'b0, '0);
    #1;
    check("byp_sdc_start", 64'(bus.sdc_start), 64'd1);
    check("byp_sdc_addr", 64'(bus.sdc_addr), 64'h800004);
    wait_done(q, lat);
    check("byp_q", 64'(q), 64'h55);
    check("byp_busy", 64'(bus.busy), 64'd0);
    #1;
    check("byp_start_drop", 64'(bus.sdc_start), 64'd0);
    do_access(24'h000010, 1'b0, '0, "after_byp_rd10");
    do_access(24'h000123, 1'b0, '0, "after_byp_rd123");

    for (int i = 0; i < 250; i++) begin
      logic [23:0] a;
      logic        w;
      if ($urandom_range(0, 9) == 0) a = LIMIT + 24'($urandom_range(0, 15));
      else a = 24'(($urandom_range(0, 3) << 9) | $urandom_range(0, 7));
      w = ($urandom_range(0, 3) == 0);
      do_access(a, w, $urandom, w ? "rnd_wr" : "rnd_rd");
    end

`ifdef L2CACHE_PERF_COUNTERS_EN
    check("perf_hits", 64'(perf_hits), 64'(exp_hits));
    check("perf_misses", 64'(perf_misses), 64'(exp_misses));
`endif

    // flush requested while a miss is outstanding
    start_req(24'h000777, 1'b0, '0);
    g = 0;
    do begin @(posedge clk); #1; g++; end while (!bus.sdc_start && g < 100);
    @(negedge clk);
    bus.flush_req = 1'b1;
    @(negedge clk);
    bus.flush_req = 1'b0;
    wait_done(q, lat);
    check("flush_miss_q", 64'(q), 64'(mem[24'h000777]));
    check("flush_busy_after_miss", 64'(bus.busy), 64'd1);
    n = 0;
    while (bus.busy && n < 2000) begin @(posedge clk); #1; n++; end
    check("flush_len_in_range", 64'(n >= 512 && n <= 514), 64'd1);
    model_flush();
    do_access(24'h000123, 1'b0, '0, "post_flush_rd123");

    // reset while a write is waiting on the SDRAM
    start_req(24'h000020, 1'b1, 32'hCAFE0001);
    g = 0;
    do begin @(posedge clk); #1; g++; end while (!bus.sdc_start && g < 100);
    check("wwait_sdc_we", 64'(bus.sdc_we), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_wwait_start_now", 64'(bus.sdc_start), 64'd0);
    @(posedge clk);
    #1;
    check("rst_wwait_start_next", 64'(bus.sdc_start), 64'd0);
    check("rst_wwait_busy", 64'(bus.busy), 64'd1);
`ifdef L2CACHE_PERF_COUNTERS_EN
    check("rst_perf_hits", 64'(perf_hits), 64'd0);
    check("rst_perf_misses", 64'(perf_misses), 64'd0);
`endif
    bus.cpu_start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (bus.busy && n < 2000) begin @(posedge clk); #1; n++; end
    check("rst_wwait_flush_len", 64'(n), 64'd512);
    model_flush();
    exp_hits = 0;
    exp_misses = 0;
    do_access(24'h000020, 1'b0, '0, "post_rst_rd20");
    do_access(24'h000020, 1'b0, '0, "post_rst_rd20_again");

`ifdef L2CACHE_PERF_COUNTERS_EN
    check("perf_hits_post_rst", 64'(perf_hits), 64'(exp_hits));
    @(negedge clk);
    perf_clear = 1'b1;
    @(negedge clk);
    perf_clear = 1'b0;
    check("perf_clear_hits", 64'(perf_hits), 64'd0);
    check("perf_clear_misses", 64'(perf_misses), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
